stream_age: RTL and testbench
=============================

Name: stream_age

Overview:
- Per-stream address generation engine (AGE).
- Walks a two-level nested-loop access pattern over the banks of one stream.
- Each cycle it emits a bank index, an in-bank word address and a valid flag.
- N_AGE_PER_STREAM instances feed the load/store stream selector, which turns the chosen AGE's bank index into the banks-PEA crossbar load select; the word address goes to the bank port.

Parameters:
- N_BANKS_PER_STREAM, 4, banks per stream; power of two.
- LOG_N_BANKS_PER_STREAM, $clog2(N_BANKS_PER_STREAM), bank index width.
- BANK_ADDR_W, 8, in-bank word address width.
- ITER_W, 8, loop-count width.
- FLAT_W, BANK_ADDR_W+LOG_N_BANKS_PER_STREAM, flat stream address width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; launches a pattern when idle.
- stall_i  in  1  downstream not ready; freezes generation.
- cfg_base_i  in  FLAT_W  flat start address.
- cfg_in_stride_i  in  FLAT_W  inner-loop increment.
- cfg_out_stride_i  in  FLAT_W  outer-loop increment, applied to the outer-row start address.
- cfg_in_len_i  in  ITER_W  inner iterations.
- cfg_out_len_i  in  ITER_W  outer iterations.
- age_bank_o  out  LOG_N_BANKS_PER_STREAM  bank index = flat[LOG_N_BANKS_PER_STREAM-1:0].
- age_addr_o  out  BANK_ADDR_W  word address = flat[FLAT_W-1:LOG_N_BANKS_PER_STREAM].
- valid_o  out  1  age_bank_o/age_addr_o are valid this cycle.
- busy_o  out  1  pattern in progress.
- done_o  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters and address registers 0.
- Reset is asynchronous and active-low, may assert at any time, and aborts any pattern with no done_o pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_i with both lengths nonzero: latch the config, set flat=row=cfg_base_i and i=j=0, go to RUN.
  - start_i with either length zero: go to DONE directly; valid_o never asserts.
- RUN:
  - valid_o=1 and busy_o=1. The first valid element appears the cycle after start_i (latency 1).
  - An element is accepted on a cycle with valid_o=1 and stall_i=0.
  - stall_i=1: hold flat, i, j and the outputs unchanged; valid_o stays 1.
  - Accept with i<in_len-1: i++, flat += in_stride.
  - Accept with i=in_len-1 and j<out_len-1: i=0, j++, row += out_stride, flat = row+out_stride.
  - Accept with i=in_len-1 and j=out_len-1: go to DONE.
- DONE: done_o=1 for exactly one cycle, busy_o=0, valid_o=0, then IDLE.
- Arithmetic: all flat additions are modulo 2^FLAT_W; wrap-around is silent, with no error flag.
- Bank index equals the flat address modulo N_BANKS_PER_STREAM, so stride 1 rotates through the banks and stride N_BANKS_PER_STREAM stays in one bank.
- start_i while in RUN or DONE is ignored. The config is sampled only at start.
- Config inputs may change during RUN without effect.
- Total valid elements accepted per pattern = in_len*out_len.

Decomposition:
- mage_pkg (shared): N_BANKS_PER_STREAM and LOG_N_BANKS_PER_STREAM. The stream selector consumes the same widths.
- mage_pkg also holds BANK_ADDR_W, FLAT_W, ITER_W and a typedef age_cfg_t packing base, both strides and both lengths.
- pea_pkg: nothing new.
- FSM enum age_state_t stays local.
- One sub-module, age_loop_cnt: the two nested counters with enable, producing wrap_inner and last flags. The address datapath and FSM remain in stream_age.

Test Plan:
1. base=0, in_stride=1, in_len=8, out_len=1, no stall -> 8 consecutive valids, banks 0,1,2,3,0,1,2,3, addrs 0,0,0,0,1,1,1,1; done_o the cycle after the 8th.
2. base=5, in_stride=4, out_stride=1, in_len=3, out_len=2 -> flat 5,9,13,6,10,14; bank always 1 then 2; addr 1,2,3,1,2,3.
3. Scenario 1 with stall_i high for 3 cycles at element 2 -> element 2 held for 4 cycles, sequence unchanged, done_o delayed by 3.
4. in_len=0, start -> no valid_o; done_o one cycle after start; busy_o stays 0.
5. base=1020 (FLAT_W=10), in_stride=3, in_len=3 -> flat 1020, 1023, 2 (wrap); bank 0,3,2; addr 255,255,0.
6. rst_n_i low mid-pattern, then start_i pulsed during RUN -> after reset, outputs 0 and no done_o; with no reset, start_i in RUN leaves the sequence undisturbed.

Source files
------------

// File: rtl/mage_pkg.sv
// Shared widths and config bundle for the per-stream address generators.
// Also consumed by the stream selector, so the bank-index width lives here.
package mage_pkg;
  localparam int N_BANKS_PER_STREAM     = 4;
  localparam int LOG_N_BANKS_PER_STREAM = $clog2(N_BANKS_PER_STREAM);
  localparam int BANK_ADDR_W            = 8;
  localparam int ITER_W                 = 8;
  localparam int FLAT_W                 = BANK_ADDR_W + LOG_N_BANKS_PER_STREAM;

  typedef struct packed {
    logic [FLAT_W-1:0] base;
    logic [FLAT_W-1:0] in_stride;
    logic [FLAT_W-1:0] out_stride;
    logic [ITER_W-1:0] in_len;
    logic [ITER_W-1:0] out_len;
  } age_cfg_t;
endpackage

// File: rtl/age_loop_cnt.sv
// Two nested iteration counters; advance on i_en, cleared by i_clr.
// Flags are combinational from the count; i_en is the only backpressure hook.
module age_loop_cnt
  import mage_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [ITER_W-1:0] i_in_len,
  input  logic [ITER_W-1:0] i_out_len,
  output logic              o_wrap_inner,
  output logic              o_last
);
  logic [ITER_W-1:0] r_i;
  logic [ITER_W-1:0] r_j;

  assign o_wrap_inner = (r_i == i_in_len - ITER_W'(1));
  assign o_last       = o_wrap_inner && (r_j == i_out_len - ITER_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_clr) begin
      r_i <= '0;
      r_j <= '0;
    end else if (i_en) begin
      if (o_wrap_inner) begin
        r_i <= '0;
        if (!o_last) r_j <= r_j + ITER_W'(1);
      end else begin
        r_i <= r_i + ITER_W'(1);
      end
    end
  end
endmodule

// File: rtl/stream_age.sv
// Two-level nested-loop address generator for one stream; first valid 1 cycle after start.
// stall_i freezes address, counters and outputs with valid_o held high.
module stream_age
  import mage_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic                              start_i,
  input  logic                              stall_i,
  input  logic [FLAT_W-1:0]                 cfg_base_i,
  input  logic [FLAT_W-1:0]                 cfg_in_stride_i,
  input  logic [FLAT_W-1:0]                 cfg_out_stride_i,
  input  logic [ITER_W-1:0]                 cfg_in_len_i,
  input  logic [ITER_W-1:0]                 cfg_out_len_i,
  output logic [LOG_N_BANKS_PER_STREAM-1:0] age_bank_o,
  output logic [BANK_ADDR_W-1:0]            age_addr_o,
  output logic                              valid_o,
  output logic                              busy_o,
  output logic                              done_o
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} age_state_t;

  age_state_t        r_state;
  age_state_t        w_state_nxt;
  age_cfg_t          w_cfg;
  logic [FLAT_W-1:0] r_flat;
  logic [FLAT_W-1:0] r_row;
  logic [FLAT_W-1:0] r_in_stride;
  logic [FLAT_W-1:0] r_out_stride;
  logic [ITER_W-1:0] r_in_len;
  logic [ITER_W-1:0] r_out_len;
  logic              w_len_ok;
  logic              w_launch;
  logic              w_accept;
  logic              w_wrap_inner;
  logic              w_last;

  assign w_cfg = '{base:       cfg_base_i,
                   in_stride:  cfg_in_stride_i,
                   out_stride: cfg_out_stride_i,
                   in_len:     cfg_in_len_i,
                   out_len:    cfg_out_len_i};

  assign w_len_ok = (|w_cfg.in_len) && (|w_cfg.out_len);
  assign w_launch = (r_state == S_IDLE) && start_i && w_len_ok;
  assign w_accept = (r_state == S_RUN) && !stall_i;

  age_loop_cnt u_loop_cnt (
    .i_clk        (clk_i),
    .i_rst_n      (rst_n_i),
    .i_clr        (w_launch),
    .i_en         (w_accept),
    .i_in_len     (r_in_len),
    .i_out_len    (r_out_len),
    .o_wrap_inner (w_wrap_inner),
    .o_last       (w_last)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    valid_o     = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // Zero-length patterns skip RUN so no element is ever presented.
        if (start_i) w_state_nxt = w_len_ok ? S_RUN : S_DONE;
      end
      S_RUN: begin
        valid_o = 1'b1;
        busy_o  = 1'b1;
        if (w_accept && w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_flat       <= '0;
      r_row        <= '0;
      r_in_stride  <= '0;
      r_out_stride <= '0;
      r_in_len     <= '0;
      r_out_len    <= '0;
    end else if (w_launch) begin
      r_flat       <= w_cfg.base;
      r_row        <= w_cfg.base;
      r_in_stride  <= w_cfg.in_stride;
      r_out_stride <= w_cfg.out_stride;
      r_in_len     <= w_cfg.in_len;
      r_out_len    <= w_cfg.out_len;
    end else if (w_accept) begin
      // Outer step restarts from the row origin, not from the last inner address.
      if (w_wrap_inner) begin
        if (!w_last) begin
          r_row  <= r_row + r_out_stride;
          r_flat <= r_row + r_out_stride;
        end
      end else begin
        r_flat <= r_flat + r_in_stride;
      end
    end
  end

  assign age_bank_o = r_flat[LOG_N_BANKS_PER_STREAM-1:0];
  assign age_addr_o = r_flat[FLAT_W-1:LOG_N_BANKS_PER_STREAM];
endmodule

// File: tb/tb_stream_age.sv
// Directed bench for stream_age: scoreboard of expected flat addresses per pattern.
module tb_stream_age;
  import mage_pkg::*;

  logic                              clk_i = 1'b0;
  logic                              rst_n_i;
  logic                              start_i;
  logic                              stall_i;
  logic [FLAT_W-1:0]                 cfg_base_i;
  logic [FLAT_W-1:0]                 cfg_in_stride_i;
  logic [FLAT_W-1:0]                 cfg_out_stride_i;
  logic [ITER_W-1:0]                 cfg_in_len_i;
  logic [ITER_W-1:0]                 cfg_out_len_i;
  logic [LOG_N_BANKS_PER_STREAM-1:0] age_bank_o;
  logic [BANK_ADDR_W-1:0]            age_addr_o;
  logic                              valid_o;
  logic                              busy_o;
  logic                              done_o;

  int tests = 0;
  int fails = 0;
  logic [FLAT_W-1:0] sb_q[$];

  stream_age dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .start_i          (start_i),
    .stall_i          (stall_i),
    .cfg_base_i       (cfg_base_i),
    .cfg_in_stride_i  (cfg_in_stride_i),
    .cfg_out_stride_i (cfg_out_stride_i),
    .cfg_in_len_i     (cfg_in_len_i),
    .cfg_out_len_i    (cfg_out_len_i),
    .age_bank_o       (age_bank_o),
    .age_addr_o       (age_addr_o),
    .valid_o          (valid_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expected address is base + j*out_stride + i*in_stride, modulo 2^FLAT_W.
  task automatic push_pattern(input logic [FLAT_W-1:0] base, input logic [FLAT_W-1:0] is,
                              input logic [FLAT_W-1:0] os, input int il, input int ol);
    for (int j = 0; j < ol; j++)
      for (int i = 0; i < il; i++)
        sb_q.push_back(FLAT_W'(int'(base) + j * int'(os) + i * int'(is)));
  endtask

  task automatic run(input string name, input logic [FLAT_W-1:0] base, input logic [FLAT_W-1:0] is,
                     input logic [FLAT_W-1:0] os, input int il, input int ol,
                     input int stall_at, input int stall_n, input bit restart_mid);
    int               n;
    int               acc;
    int               stalled;
    int               cyc;
    int               done_cyc;
    bit               done_seen;
    bit               expect_done;
    logic [FLAT_W-1:0] exp_flat;
    n           = il * ol;
    acc         = 0;
    stalled     = 0;
    cyc         = 0;
    done_cyc    = -1;
    done_seen   = 1'b0;
    expect_done = (n == 0);
    push_pattern(base, is, os, il, ol);
    cfg_base_i       = base;
    cfg_in_stride_i  = is;
    cfg_out_stride_i = os;
    cfg_in_len_i     = ITER_W'(il);
    cfg_out_len_i    = ITER_W'(ol);
    start_i          = 1'b1;
    tick();
    start_i          = 1'b0;
    cfg_base_i       = FLAT_W'($urandom);
    cfg_in_stride_i  = FLAT_W'($urandom);
    cfg_out_stride_i = FLAT_W'($urandom);
    cfg_in_len_i     = ITER_W'($urandom_range(1, 255));
    cfg_out_len_i    = ITER_W'($urandom_range(1, 255));
    while (!done_seen && cyc < 200) begin
      stall_i = (acc == stall_at) && (stalled < stall_n);
      start_i = restart_mid && (acc == 3);
      if (expect_done) begin
        chk({name, ".done"}, done_o, 1);
        chk({name, ".done_busy"}, busy_o, 0);
        chk({name, ".done_valid"}, valid_o, 0);
        done_seen = 1'b1;
        done_cyc  = cyc;
      end else begin
        chk({name, ".early_done"}, done_o, 0);
        chk({name, ".valid"}, valid_o, 1);
        chk({name, ".busy"}, busy_o, 1);
        if (valid_o && sb_q.size() > 0) begin
          exp_flat = sb_q[0];
          chk({name, ".bank"}, age_bank_o, exp_flat[LOG_N_BANKS_PER_STREAM-1:0]);
          chk({name, ".addr"}, age_addr_o, exp_flat[FLAT_W-1:LOG_N_BANKS_PER_STREAM]);
          if (!stall_i) begin
            void'(sb_q.pop_front());
            acc++;
            if (acc == n) expect_done = 1'b1;
          end else begin
            stalled++;
          end
        end
      end
      tick();
      cyc++;
    end
    stall_i = 1'b0;
    start_i = 1'b0;
    chk({name, ".finished"}, done_seen, 1);
    chk({name, ".done_cycle"}, done_cyc, n + stall_n);
    chk({name, ".accepted"}, acc, n);
    chk({name, ".idle_done"}, done_o, 0);
    chk({name, ".idle_valid"}, valid_o, 0);
    sb_q.delete();
  endtask

  initial begin
    rst_n_i          = 1'b0;
    start_i          = 1'b0;
    stall_i          = 1'b0;
    cfg_base_i       = '0;
    cfg_in_stride_i  = '0;
    cfg_out_stride_i = '0;
    cfg_in_len_i     = '0;
    cfg_out_len_i    = '0;
    #12;
    chk("rst.valid", valid_o, 0);
    chk("rst.busy", busy_o, 0);
    chk("rst.done", done_o, 0);
    chk("rst.bank", age_bank_o, 0);
    chk("rst.addr", age_addr_o, 0);
    tick();
    rst_n_i = 1'b1;
    tick();

    run("t1_linear", 10'd0, 10'd1, 10'd0, 8, 1, -1, 0, 1'b0);
    run("t2_nested", 10'd5, 10'd4, 10'd1, 3, 2, -1, 0, 1'b0);
    run("t3_stall", 10'd0, 10'd1, 10'd0, 8, 1, 2, 3, 1'b0);
    run("t4_zero_in", 10'd7, 10'd1, 10'd1, 0, 3, -1, 0, 1'b0);
    run("t4_zero_out", 10'd7, 10'd1, 10'd1, 2, 0, -1, 0, 1'b0);
    run("t5_wrap", 10'd1020, 10'd3, 10'd0, 3, 1, -1, 0, 1'b0);
    run("t5_bank_lock", 10'd2, 10'd4, 10'd1021, 2, 3, 1, 2, 1'b0);

    // Reset mid-pattern: everything drops immediately and no done pulse follows.
    cfg_base_i      = 10'd0;
    cfg_in_stride_i = 10'd1;
    cfg_in_len_i    = 8'd8;
    cfg_out_len_i   = 8'd1;
    start_i         = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    chk("t6.pre_rst_valid", valid_o, 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("t6.rst_valid", valid_o, 0);
    chk("t6.rst_busy", busy_o, 0);
    chk("t6.rst_addr", {age_addr_o, age_bank_o}, 0);
    tick();
    rst_n_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("t6.post_rst_quiet", {done_o, busy_o, valid_o}, 0);
      tick();
    end

    run("t6_restart_ignored", 10'd3, 10'd2, 10'd16, 4, 2, -1, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
